cpu_control_unit: RTL

Moore-style multicycle control unit for the simple CPU: fetches 16-bit instructions from instruction memory, decodes them and sequences the existing register-file/ALU datapath and the data memory. It sits between instruction ROM, data RAM and the datapath; the datapath's `RF_Rp_zero` flag is its only status input.

---
 rtl/cpu_control_unit_if.sv | 49 ++++
 rtl/cpu_control_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit_if.sv
// Instruction ROM, data RAM and datapath control bundle of the multicycle control unit.
// Latency: none; plain wires grouped for connection.
// Backpressure: none; the ROM answers combinationally and the datapath always accepts.
interface cpu_control_unit_if #(
   parameter int PC_W = 8
);
   // instruction ROM
   logic [15:0]     I_data;
   logic [PC_W-1:0] I_addr;
   logic            I_rd;
   // data RAM
   logic [7:0]      D_addr;
   logic            D_rd;
   logic            D_wr;
   // register file / write mux
   logic [7:0]      RF_W_data;
   logic            RF_s1;
   logic            RF_s0;
   logic [3:0]      RF_W_addr;
   logic            RF_W_wr;
   logic [3:0]      RF_Rp_addr;
   logic            RF_Rp_rd;
   logic [3:0]      RF_Rq_addr;
   logic            RF_Rq_rd;
   logic            RF_Rp_zero;
   // ALU
   logic            alu_s1;
   logic            alu_s0;
   // status
   logic            halted;

   // control unit side
   modport master (
      input  I_data, RF_Rp_zero,
      output I_addr, I_rd, D_addr, D_rd, D_wr,
             RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
             RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
             alu_s1, alu_s0, halted
   );

   // memories / datapath side
   modport slave (
      output I_data, RF_Rp_zero,
      input  I_addr, I_rd, D_addr, D_rd, D_wr,
             RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
             RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
             alu_s1, alu_s0, halted
   );
endinterface

// File: rtl/cpu_control_unit.sv
// Moore multicycle control unit: fetch/decode/execute sequencing for the simple 16-bit CPU.
// Latency: 3 cycles per instruction, 4 for a taken JMPZ, 2 for an illegal opcode; first fetch 2nd edge after reset.
// Backpressure: none; ROM/RAM/datapath are single-cycle. Optional macro CPU_JMP_EN adds JMP (opcode 0110).
module cpu_control_unit #(
   parameter int PC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   cpu_control_unit_if.master  bus
);

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_LDC   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_JMPZ  = 4'b0101;
`ifdef CPU_JMP_EN
   localparam logic [3:0] OP_JMP   = 4'b0110;
`endif
   localparam logic [3:0] OP_HALT  = 4'b1111;

   // immediate is sign-extended to at least the PC width for branch offsets
   localparam int EW = (PC_W > 8) ? PC_W : 8;

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_LDC,
      S_SUB,
      S_JMPZ,
      S_JMPZ_JMP,
`ifdef CPU_JMP_EN
      S_JMP,
`endif
      S_HALT
   } state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [15:0]     ir, ir_nxt;

   logic [3:0]      op, ra, rb, rc;
   logic [7:0]      imm;
   logic [EW-1:0]   imm_sx;
   logic [PC_W-1:0] pc_branch;

   assign op  = ir[15:12];
   assign ra  = ir[11:8];
   assign rb  = ir[7:4];
   assign rc  = ir[3:0];
   assign imm = ir[7:0];

   // PC already points past the branch, so subtract one to make the offset relative to the branch itself
   assign imm_sx    = EW'($signed(imm));
   assign pc_branch = pc + imm_sx[PC_W-1:0] - PC_W'(1);

   // instruction address always tracks the PC
   assign bus.I_addr = pc;

   // state, PC and IR registers; reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_INIT;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   // next-state, PC/IR updates and Moore outputs decoded from state and IR
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      ir_nxt         = ir;
      bus.I_rd       = 1'b0;
      bus.D_addr     = '0;
      bus.D_rd       = 1'b0;
      bus.D_wr       = 1'b0;
      bus.RF_W_data  = '0;
      bus.RF_s1      = 1'b0;
      bus.RF_s0      = 1'b0;
      bus.RF_W_addr  = '0;
      bus.RF_W_wr    = 1'b0;
      bus.RF_Rp_addr = '0;
      bus.RF_Rp_rd   = 1'b0;
      bus.RF_Rq_addr = '0;
      bus.RF_Rq_rd   = 1'b0;
      bus.alu_s1     = 1'b0;
      bus.alu_s0     = 1'b0;
      bus.halted     = 1'b0;

      case (state)
         S_INIT: begin
            pc_nxt    = '0;
            state_nxt = S_FETCH;
         end

         S_FETCH: begin
            bus.I_rd  = 1'b1;
            ir_nxt    = bus.I_data;
            pc_nxt    = pc + PC_W'(1);
            state_nxt = S_DECODE;
         end

         S_DECODE: begin
            case (op)
               OP_LOAD:  state_nxt = S_LOAD;
               OP_STORE: state_nxt = S_STORE;
               OP_ADD:   state_nxt = S_ADD;
               OP_LDC:   state_nxt = S_LDC;
               OP_SUB:   state_nxt = S_SUB;
               OP_JMPZ:  state_nxt = S_JMPZ;
`ifdef CPU_JMP_EN
               OP_JMP:   state_nxt = S_JMP;
`endif
               OP_HALT:  state_nxt = S_HALT;
               default:  state_nxt = S_FETCH;   // illegal opcode executes as NOP
            endcase
         end

         S_LOAD: begin
            bus.D_addr    = imm;
            bus.D_rd      = 1'b1;
            bus.RF_s0     = 1'b1;
            bus.RF_W_addr = ra;
            bus.RF_W_wr   = 1'b1;
            state_nxt     = S_FETCH;
         end

         S_STORE: begin
            bus.D_addr     = imm;
            bus.D_wr       = 1'b1;
            bus.RF_Rp_addr = ra;
            bus.RF_Rp_rd   = 1'b1;
            state_nxt      = S_FETCH;
         end

         S_ADD: begin
            bus.RF_Rp_addr = rb;
            bus.RF_Rp_rd   = 1'b1;
            bus.RF_Rq_addr = rc;
            bus.RF_Rq_rd   = 1'b1;
            bus.alu_s0     = 1'b1;
            bus.RF_W_addr  = ra;
            bus.RF_W_wr    = 1'b1;
            state_nxt      = S_FETCH;
         end

         S_SUB: begin
            bus.RF_Rp_addr = rb;
            bus.RF_Rp_rd   = 1'b1;
            bus.RF_Rq_addr = rc;
            bus.RF_Rq_rd   = 1'b1;
            bus.alu_s1     = 1'b1;
            bus.RF_W_addr  = ra;
            bus.RF_W_wr    = 1'b1;
            state_nxt      = S_FETCH;
         end

         S_LDC: begin
            bus.RF_W_data = imm;
            bus.RF_s1     = 1'b1;
            bus.RF_W_addr = ra;
            bus.RF_W_wr   = 1'b1;
            state_nxt     = S_FETCH;
         end

         S_JMPZ: begin
            bus.RF_Rp_addr = ra;
            bus.RF_Rp_rd   = 1'b1;
            state_nxt      = bus.RF_Rp_zero ? S_JMPZ_JMP : S_FETCH;
         end

         S_JMPZ_JMP: begin
            pc_nxt    = pc_branch;
            state_nxt = S_FETCH;
         end

`ifdef CPU_JMP_EN
         S_JMP: begin
            pc_nxt    = pc_branch;
            state_nxt = S_FETCH;
         end
`endif

         S_HALT: begin
            bus.halted = 1'b1;
            state_nxt  = S_HALT;
         end

         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

endmodule
